// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
// State encodings and a one-hot-or-zero check helper.
package arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ARB_IDLE,
    S_BUSY = ARB_BUSY
  } arb_state_e;

  // True when at most one bit of v is set.
  function automatic logic ONEHOT0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Scans ptr, ptr+1, ... mod N over req with masked bits ignored.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [N-1:0] elig;

  assign elig = req & ~mask;

  // First eligible bit at or after ptr, wrapping.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && elig[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and index.
// Define RR_ARB_LOCK_EN to hold the grant across multi-beat bursts.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]     req_last,
`endif
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             out_valid
);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             busy;
  logic             accept;
  logic             complete;
  logic             violation;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     pick_mask;
  logic [N-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  assign busy      = (state_q == S_BUSY);
  assign out_valid = busy & req[idx_q];
  assign accept    = out_valid & out_ready;

`ifdef RR_ARB_LOCK_EN
  assign complete  = accept & req_last[idx_q];
`else
  assign complete  = accept;
`endif

  assign violation = busy & ~req[idx_q];

  assign nxt_ptr   = (idx_q == IDX_W'(N - 1)) ?
                     '0 : idx_q + IDX_W'(1);

  // On completion re-arbitrate from the rotated
  // pointer with the just-served requester masked.
  assign pick_ptr  = complete ? nxt_ptr : ptr_q;
  assign pick_mask = complete ? gnt_q : '0;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .mask    (pick_mask),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // Next state, next grant and pointer update.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          gnt_d   = win;
          idx_d   = win_idx;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (complete) begin
          ptr_d = nxt_ptr;
          if (win_any) begin
            gnt_d = win;
            idx_d = win_idx;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end else if (violation) begin
          gnt_d   = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grant is zero or one-hot and agrees with its index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (ONEHOT0(32'(gnt_q)))
        else $error("gnt not onehot0");
      assert (gnt_q == '0 || gnt_q[idx_q])
        else $error("gnt_idx disagrees with gnt");
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter, N=4.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
`ifdef RR_ARB_LOCK_EN
  logic [N-1:0] req_last;
`endif
  logic         out_ready;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         out_valid;

  int n_vec;
  int n_bad;

  rr_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef RR_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag,
                       input logic [3:0] eg,
                       input logic [1:0] ei,
                       input logic ev);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".vld"}, 32'(out_valid), 32'(ev));
    chk({tag, ".oh0"}, 32'(ONEHOT0(32'(gnt))), 32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
    req_last  = 4'b1111;
`endif
    #1;
    tick();
    tick();
    chk_g("reset", 4'b0000, 2'd0, 1'b0);

    rst = 1'b0;
    tick();
    chk_g("first", 4'b0001, 2'd0, 1'b1);

    tick();
    chk_g("rot1", 4'b0010, 2'd1, 1'b1);
    tick();
    chk_g("rot2", 4'b0100, 2'd2, 1'b1);
    tick();
    chk_g("rot3", 4'b1000, 2'd3, 1'b1);
    tick();
    chk_g("rot0", 4'b0001, 2'd0, 1'b1);

    req       = 4'b0110;
    out_ready = 1'b0;
    tick();
    chk_g("viol0", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_g("bp_gnt", 4'b0010, 2'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_g("bp_hold", 4'b0010, 2'd1, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk_g("bp_rel", 4'b0100, 2'd2, 1'b1);

    req = 4'b1000;
    tick();
    chk_g("lone_v", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_g("lone_a", 4'b1000, 2'd3, 1'b1);
    tick();
    chk_g("lone_b", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_g("lone_c", 4'b1000, 2'd3, 1'b1);

    req = 4'b1001;
    tick();
    chk_g("wd_g0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0011;
    tick();
    chk_g("wd_g1", 4'b0010, 2'd1, 1'b1);
    out_ready = 1'b0;
    req       = 4'b0000;
    #1;
    chk("wd_vld", 32'(out_valid), 32'd0);
    tick();
    chk_g("wd_idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0111;
    tick();
    chk_g("wd_ptr", 4'b0010, 2'd1, 1'b1);

    req = 4'b1111;
    rst = 1'b1;
    tick();
    chk_g("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_g("rst_rel", 4'b0001, 2'd0, 1'b1);

    req       = 4'b0011;
    out_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
    req_last  = 4'b0000;
    tick();
    chk_g("lock_b1", 4'b0001, 2'd0, 1'b1);
    tick();
    chk_g("lock_b2", 4'b0001, 2'd0, 1'b1);
    req_last = 4'b0001;
    tick();
    chk_g("lock_end", 4'b0010, 2'd1, 1'b1);
`else
    tick();
    chk_g("nolock_a", 4'b0010, 2'd1, 1'b1);
    tick();
    chk_g("nolock_b", 4'b0001, 2'd0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
